// File: rtl/seq_fetch_unit.sv
// rtl/seq_fetch_unit.sv - program counter and sequence word fetch front end
//
// Purpose:
//   Owns the program counter and reads one sequence word at a time from a
//   synchronous program memory. Each fetched word is handed to the decoder
//   and executor over a valid/ready handshake. When a word is accepted, the
//   next PC is chosen from one of three sources: halt, a taken jump, or PC+1.
//   A next PC that would fall outside the memory ends the run with a sticky
//   error.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i, start_addr_i  start a run at start_addr_i (honoured only in IDLE)
//   stop_i                 abort; any state returns to IDLE
//   mem_rd_o, mem_addr_o   program memory read strobe / address (= PC)
//   mem_rdata_i            read data, valid one cycle after mem_rd_o
//   word_o, word_valid_o   fetched word to decoder, qualified by valid
//   word_ready_i           executor accepts word_o
//   jmp_en_i, jmp_dir_up_i, jmp_value_i
//                          decoder jump info (dir_up = toward lower addresses)
//   jmp_take_i             executor jump condition result
//   halt_i                 accepted word ends the run
//   pc_o, busy_o           current PC, not-idle indicator
//   done_o                 one-cycle pulse on normal run end
//   err_o                  sticky range error, cleared by an accepted start

module seq_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 16,
   parameter int JMP_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic              stop_i,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [WORD_W-1:0] mem_rdata_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   input  logic              jmp_en_i,
   input  logic              jmp_dir_up_i,
   input  logic [JMP_W-1:0]  jmp_value_i,
   input  logic              jmp_take_i,
   input  logic              halt_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // Target arithmetic is wide enough for both operands plus a carry bit and
   // a sign bit, so an out-of-range result can never alias into a legal PC.
   localparam int CW = ((JMP_W > ADDR_W) ? JMP_W : ADDR_W) + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                err_q, err_d;
   logic                done_d;

   logic                accept;
   logic [CW-1:0]       pc_ext;
   logic [CW-1:0]       jmp_ext;
   logic [CW-1:0]       target;
   logic                range_err;

   assign accept  = (state_q == S_VALID) && word_ready_i;
   assign pc_ext  = CW'(pc_q);
   assign jmp_ext = CW'(jmp_value_i);

   always_comb begin
      target = pc_ext + CW'(1);
      if (jmp_en_i && jmp_take_i) begin
         if (jmp_dir_up_i) begin
            target = pc_ext - jmp_ext;
         end else begin
            target = pc_ext + jmp_ext;
         end
      end
   end

   // Negative (sign bit) or beyond the top of memory (any bit above ADDR_W).
   assign range_err = target[CW-1] | (|target[CW-2:ADDR_W]);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      word_d  = word_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pc_d    = start_addr_i;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            word_d  = mem_rdata_i;
            state_d = S_VALID;
         end
         S_VALID: begin
            if (accept) begin
               if (halt_i) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (range_err) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  pc_d    = target[ADDR_W-1:0];
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything decided above, including a start in IDLE.
      if (stop_i) begin
         state_d = S_IDLE;
         pc_d    = pc_q;
         word_d  = word_q;
         err_d   = err_q;
         done_d  = 1'b0;
      end
   end

   // Strobes are registered from the next state so they line up with the
   // state they describe while still coming straight out of flops.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         word_q       <= '0;
         err_q        <= 1'b0;
         done_o       <= 1'b0;
         mem_rd_o     <= 1'b0;
         word_valid_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         word_q       <= word_d;
         err_q        <= err_d;
         done_o       <= done_d;
         mem_rd_o     <= (state_d == S_FETCH);
         word_valid_o <= (state_d == S_VALID);
         busy_o       <= (state_d != S_IDLE);
      end
   end

   assign mem_addr_o = pc_q;
   assign pc_o       = pc_q;
   assign word_o     = word_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_seq_fetch_unit.sv
// tb/tb_seq_fetch_unit.sv - directed self-checking bench for seq_fetch_unit

module tb_seq_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  start_addr;
   logic        stop;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic [15:0] word;
   logic        word_valid;
   logic        word_ready;
   logic        jmp_en;
   logic        jmp_dir_up;
   logic [7:0]  jmp_value;
   logic        jmp_take;
   logic        halt;
   logic [7:0]  pc;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   seq_fetch_unit #(.ADDR_W(8), .WORD_W(16), .JMP_W(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_addr_i (start_addr),
      .stop_i       (stop),
      .mem_rd_o     (mem_rd),
      .mem_addr_o   (mem_addr),
      .mem_rdata_i  (mem_rdata),
      .word_o       (word),
      .word_valid_o (word_valid),
      .word_ready_i (word_ready),
      .jmp_en_i     (jmp_en),
      .jmp_dir_up_i (jmp_dir_up),
      .jmp_value_i  (jmp_value),
      .jmp_take_i   (jmp_take),
      .halt_i       (halt),
      .pc_o         (pc),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {8'hA5, a};
   endfunction

   // Synchronous memory; garbage when not read so a mistimed capture shows.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem_word(mem_addr);
      else        mem_rdata <= 16'hDEAD;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic start_run(input logic [7:0] a);
      start = 1'b1;
      start_addr = a;
      step;
      start = 1'b0;
   endtask

   // Called at the negedge of a FETCH cycle; returns at the negedge of VALID.
   task automatic fetch_word(input logic [7:0] a, input string tag);
      check({tag, ".rd"},    32'(mem_rd), 32'd1);
      check({tag, ".addr"},  32'(mem_addr), 32'(a));
      check({tag, ".vld_f"}, 32'(word_valid), 32'd0);
      step;
      check({tag, ".rd_w"},  32'(mem_rd), 32'd0);
      check({tag, ".vld_w"}, 32'(word_valid), 32'd0);
      step;
      check({tag, ".vld"},   32'(word_valid), 32'd1);
      check({tag, ".word"},  32'(word), 32'(mem_word(a)));
      check({tag, ".pc"},    32'(pc), 32'(a));
   endtask

   initial begin
      int loop_pc[10] = '{10, 7, 8, 9, 10, 7, 8, 9, 10, 11};

      rst_n = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0;
      word_ready = 1'b1; jmp_en = 1'b0; jmp_dir_up = 1'b0; jmp_value = '0;
      jmp_take = 1'b0; halt = 1'b0;
      step; step; step;
      check("rst.pc",   32'(pc), 32'd0);
      check("rst.word", 32'(word), 32'd0);
      check("rst.vld",  32'(word_valid), 32'd0);
      check("rst.rd",   32'(mem_rd), 32'd0);
      check("rst.addr", 32'(mem_addr), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.err",  32'(err), 32'd0);
      rst_n = 1'b1;
      step;

      // Linear run 4..6, halt on 6
      start_run(8'd4);
      check("lin.busy", 32'(busy), 32'd1);
      fetch_word(8'd4, "lin4"); step;
      fetch_word(8'd5, "lin5"); step;
      fetch_word(8'd6, "lin6");
      halt = 1'b1; step; halt = 1'b0;
      check("lin.done", 32'(done), 32'd1);
      check("lin.busy_end", 32'(busy), 32'd0);
      check("lin.vld_end", 32'(word_valid), 32'd0);
      step;
      check("lin.done_pulse", 32'(done), 32'd0);
      check("lin.rd_end", 32'(mem_rd), 32'd0);

      // Backward loop at 10: jump up 3 taken twice, then not taken
      start_run(8'd10);
      for (int i = 0; i < 10; i++) begin
         fetch_word(8'(loop_pc[i]), $sformatf("loop%0d", i));
         jmp_en     = (i == 0 || i == 4 || i == 8);
         jmp_take   = (i != 8);
         jmp_dir_up = 1'b1;
         jmp_value  = 8'd3;
         halt       = (i == 9);
         step;
         jmp_en = 1'b0; jmp_take = 1'b0; halt = 1'b0;
      end
      check("loop.done", 32'(done), 32'd1);
      step;

      // Zero-offset jump refetches, then forward jump by 5
      start_run(8'd20);
      fetch_word(8'd20, "j0a");
      jmp_en = 1'b1; jmp_take = 1'b1; jmp_dir_up = 1'b0; jmp_value = 8'd0;
      step;
      fetch_word(8'd20, "j0b");
      jmp_value = 8'd5;
      step;
      jmp_en = 1'b0; jmp_take = 1'b0;
      fetch_word(8'd25, "fwd");
      halt = 1'b1; step; halt = 1'b0;
      check("fwd.done", 32'(done), 32'd1);
      check("fwd.err", 32'(err), 32'd0);
      step;

      // Stall for 5 cycles in VALID
      start_run(8'd30);
      fetch_word(8'd30, "stl");
      word_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step;
         check("stl.word", 32'(word), 32'(mem_word(8'd30)));
         check("stl.pc", 32'(pc), 32'd30);
         check("stl.vld", 32'(word_valid), 32'd1);
         check("stl.rd", 32'(mem_rd), 32'd0);
      end
      word_ready = 1'b1;
      step;
      fetch_word(8'd31, "stl31");
      halt = 1'b1; step; halt = 1'b0;
      check("stl.done", 32'(done), 32'd1);
      step;

      // Range error: 250 + 10 overflows
      start_run(8'd250);
      fetch_word(8'd250, "ov");
      jmp_en = 1'b1; jmp_take = 1'b1; jmp_dir_up = 1'b0; jmp_value = 8'd10;
      step;
      jmp_en = 1'b0; jmp_take = 1'b0;
      check("ov.err", 32'(err), 32'd1);
      check("ov.busy", 32'(busy), 32'd0);
      check("ov.done", 32'(done), 32'd0);
      check("ov.pc", 32'(pc), 32'd250);
      step;
      check("ov.err_sticky", 32'(err), 32'd1);
      check("ov.rd", 32'(mem_rd), 32'd0);

      // Start clears err; non-jump accept at 255 errors
      start_run(8'd255);
      check("top.err_clr", 32'(err), 32'd0);
      fetch_word(8'd255, "top");
      step;
      check("top.err", 32'(err), 32'd1);
      check("top.done", 32'(done), 32'd0);
      check("top.busy", 32'(busy), 32'd0);
      step;

      // Underflow: 2 - 3
      start_run(8'd2);
      fetch_word(8'd2, "un");
      jmp_en = 1'b1; jmp_take = 1'b1; jmp_dir_up = 1'b1; jmp_value = 8'd3;
      step;
      jmp_en = 1'b0; jmp_take = 1'b0;
      check("un.err", 32'(err), 32'd1);
      check("un.busy", 32'(busy), 32'd0);
      step;

      // Boundary: 245 + 10 = 255 is legal
      start_run(8'd245);
      fetch_word(8'd245, "bnd");
      jmp_en = 1'b1; jmp_take = 1'b1; jmp_dir_up = 1'b0; jmp_value = 8'd10;
      step;
      jmp_en = 1'b0; jmp_take = 1'b0;
      check("bnd.err", 32'(err), 32'd0);
      fetch_word(8'd255, "bnd255");
      halt = 1'b1; step; halt = 1'b0;
      check("bnd.done", 32'(done), 32'd1);
      step;

      // Abort in WAIT
      start_run(8'd40);
      step;
      stop = 1'b1; step; stop = 1'b0;
      check("abw.busy", 32'(busy), 32'd0);
      check("abw.vld", 32'(word_valid), 32'd0);
      check("abw.rd", 32'(mem_rd), 32'd0);
      check("abw.done", 32'(done), 32'd0);
      step;
      check("abw.rd2", 32'(mem_rd), 32'd0);
      check("abw.vld2", 32'(word_valid), 32'd0);

      // Abort beats accept + halt
      start_run(8'd50);
      fetch_word(8'd50, "abh");
      halt = 1'b1; stop = 1'b1; step; halt = 1'b0; stop = 1'b0;
      check("abh.done", 32'(done), 32'd0);
      check("abh.busy", 32'(busy), 32'd0);
      check("abh.vld", 32'(word_valid), 32'd0);
      step;
      check("abh.rd", 32'(mem_rd), 32'd0);
      check("abh.done2", 32'(done), 32'd0);

      // Abort beats start in IDLE
      start = 1'b1; stop = 1'b1; start_addr = 8'd70; step;
      start = 1'b0; stop = 1'b0;
      check("abs.busy", 32'(busy), 32'd0);
      check("abs.rd", 32'(mem_rd), 32'd0);

      // Start ignored while busy, then reset mid-run
      start_run(8'd60);
      fetch_word(8'd60, "ign");
      word_ready = 1'b0; start = 1'b1; start_addr = 8'd100;
      step;
      start = 1'b0;
      check("ign.pc", 32'(pc), 32'd60);
      check("ign.vld", 32'(word_valid), 32'd1);
      word_ready = 1'b1;
      step;
      fetch_word(8'd61, "ign61");
      word_ready = 1'b0; rst_n = 1'b0;
      step;
      check("mrst.pc", 32'(pc), 32'd0);
      check("mrst.word", 32'(word), 32'd0);
      check("mrst.vld", 32'(word_valid), 32'd0);
      check("mrst.rd", 32'(mem_rd), 32'd0);
      check("mrst.addr", 32'(mem_addr), 32'd0);
      check("mrst.busy", 32'(busy), 32'd0);
      check("mrst.done", 32'(done), 32'd0);
      check("mrst.err", 32'(err), 32'd0);
      rst_n = 1'b1; word_ready = 1'b1;
      step;
      check("mrst.idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
